// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: size codes, FSM
// state encoding and the size-to-byte-count helper.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10,
        ST_ERR    = 2'b11
    } state_e;

    // Size code 1x is a word access, matching the RAM mask encoding.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Load/store initiator for the byte-addressed data RAM: validates alignment
// and range, drives the RAM port for one cycle and returns a one-cycle response.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          ADDR_BITS   = 10,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [1:0]  ram_mask,
    output logic        ram_signed_ext,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [32:0] RAM_BYTES = 33'd1 << ADDR_BITS;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic        signed_q, signed_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [1:0]  ram_mask_q, ram_mask_d;
    logic        ram_signed_ext_q, ram_signed_ext_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic        ram_we_q, ram_we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] offset_s;
    logic [2:0]  bytes_s;
    logic [32:0] end_s;
    logic        misalign_s;
    logic        range_err_s;
    logic        addr_err_s;

    // Alignment and range check of the incoming request; 33-bit end avoids wrap.
    always_comb begin
        offset_s    = req_addr - BASE_ADDR;
        bytes_s     = size_bytes(req_size);
        end_s       = {1'b0, offset_s} + {30'd0, bytes_s};
        range_err_s = (end_s > RAM_BYTES);
        misalign_s  = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
        addr_err_s  = (CHECK_ALIGN && misalign_s) || range_err_s;
    end

    // Next-state, request latching and response generation.
    always_comb begin
        state_d          = state_q;
        we_d             = we_q;
        signed_d         = signed_q;
        ram_addr_d       = ram_addr_q;
        ram_mask_d       = ram_mask_q;
        ram_signed_ext_d = ram_signed_ext_q;
        ram_wdata_d      = ram_wdata_q;
        ram_we_d         = 1'b0;
        rdata_d          = rdata_q;
        resp_valid_d     = 1'b0;
        resp_err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d             = req_we;
                    signed_d         = req_signed;
                    ram_addr_d       = offset_s;
                    ram_mask_d       = req_size;
                    ram_signed_ext_d = req_signed & ~req_we;
                    ram_wdata_d      = req_wdata;
                    rdata_d          = 32'd0;
                    if (addr_err_s) begin
                        state_d      = ST_ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d      = ST_ACCESS;
                        ram_we_d     = req_we;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    rdata_d = 32'd0;
                end else begin
                    rdata_d = ram_rdata;
                end
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, request latches and registered RAM/response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            we_q             <= 1'b0;
            signed_q         <= 1'b0;
            ram_addr_q       <= 32'd0;
            ram_mask_q       <= 2'b00;
            ram_signed_ext_q <= 1'b0;
            ram_wdata_q      <= 32'd0;
            ram_we_q         <= 1'b0;
            rdata_q          <= 32'd0;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            we_q             <= we_d;
            signed_q         <= signed_d;
            ram_addr_q       <= ram_addr_d;
            ram_mask_q       <= ram_mask_d;
            ram_signed_ext_q <= ram_signed_ext_d;
            ram_wdata_q      <= ram_wdata_d;
            ram_we_q         <= ram_we_d;
            rdata_q          <= rdata_d;
            resp_valid_q     <= resp_valid_d;
            resp_err_q       <= resp_err_d;
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = rdata_q;
    assign ram_we         = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_mask       = ram_mask_q;
    assign ram_signed_ext = ram_signed_ext_q;
    assign ram_wdata      = ram_wdata_q;

    logic unused_s;
    assign unused_s = signed_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a byte-array RAM
// and a reference memory model computed from the access rules.
module tb_mem_access_unit;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int          RAM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        ram_we, ram_signed_ext;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [1:0]  ram_mask;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cycles = 0;
    logic preload = 1'b0;

    logic [7:0] ram_mem [0:RAM_SIZE-1];
    logic [7:0] ref_mem [0:RAM_SIZE-1];

    always #5 clk = ~clk;

    mem_access_unit #(
        .BASE_ADDR  (BASE),
        .ADDR_BITS  (10),
        .CHECK_ALIGN(1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_err      (resp_err),
        .resp_rdata    (resp_rdata),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_mask      (ram_mask),
        .ram_signed_ext(ram_signed_ext),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    // Data RAM: combinational read with extension, synchronous masked write.
    logic [9:0]  ra;
    logic [31:0] raw;
    assign ra  = ram_addr[9:0];
    assign raw = {ram_mem[ra + 10'd3], ram_mem[ra + 10'd2], ram_mem[ra + 10'd1], ram_mem[ra]};
    assign ram_rdata = ram_mask[1] ? raw :
                       ram_mask[0] ? {{16{ram_signed_ext & raw[15]}}, raw[15:0]} :
                                     {{24{ram_signed_ext & raw[7]}}, raw[7:0]};

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < RAM_SIZE; i++) ram_mem[i] <= ref_mem[i];
        end else if (ram_we) begin
            ram_mem[ra] <= ram_wdata[7:0];
            if (ram_mask != 2'b00) ram_mem[ra + 10'd1] <= ram_wdata[15:8];
            if (ram_mask[1]) begin
                ram_mem[ra + 10'd2] <= ram_wdata[23:16];
                ram_mem[ra + 10'd3] <= ram_wdata[31:24];
            end
            we_cycles <= we_cycles + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        if (size == 2'b00) return 1;
        if (size == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_err(input logic [31:0] addr, input logic [1:0] size);
        int n = nbytes(size);
        longint unsigned off = longint'(addr - BASE) & 64'hFFFF_FFFF;
        if ((addr % n) != 0) return 1'b1;
        return (off + n) > RAM_SIZE;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size, input bit sgn);
        int n = nbytes(size);
        int off = int'(addr - BASE);
        longint unsigned v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[off + i]) << (8 * i);
        if (sgn && n < 4 && v >= (64'd1 << (8 * n - 1)))
            v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
        return 32'(v);
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        int n = nbytes(size);
        int off = int'(addr - BASE);
        for (int i = 0; i < n; i++) ref_mem[off + i] = 8'((wdata >> (8 * i)) & 32'hFF);
    endtask

    task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
        bit          exp_err;
        logic [31:0] off, exp_rd;
        int          we_before, w;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        w = 0;
        while (!req_ready && w < 8) begin @(posedge clk); #1; w++; end
        check("ready_before_accept", {31'd0, req_ready}, 32'd1);
        exp_err = model_err(addr, size);
        off = addr - BASE;
        exp_rd = (we || exp_err) ? 32'd0 : model_load(addr, size, sgn);
        we_before = we_cycles;
        @(posedge clk); #1;
        if (hold) begin
            req_addr = addr ^ 32'h0000_0044; req_we = ~we;
        end else begin
            req_valid = 1'b0;
        end
        if (exp_err) begin
            check("err_valid", {31'd0, resp_valid}, 32'd1);
            check("err_flag",  {31'd0, resp_err},   32'd1);
            check("err_rdata", resp_rdata,          32'd0);
            check("err_ram_we", {31'd0, ram_we},    32'd0);
            check("err_ready", {31'd0, req_ready},  32'd0);
        end else begin
            check("acc_valid", {31'd0, resp_valid}, 32'd0);
            check("acc_ram_we", {31'd0, ram_we},    {31'd0, we});
            check("acc_addr",  ram_addr,            off);
            check("acc_mask",  {30'd0, ram_mask},   {30'd0, size});
            check("acc_sext",  {31'd0, ram_signed_ext}, {31'd0, sgn & ~we});
            check("acc_ready", {31'd0, req_ready},  32'd0);
            if (we) check("acc_wdata", ram_wdata, wdata);
            @(posedge clk); #1;
            check("rsp_valid", {31'd0, resp_valid}, 32'd1);
            check("rsp_err",   {31'd0, resp_err},   32'd0);
            check("rsp_rdata", resp_rdata,          exp_rd);
            check("rsp_ram_we", {31'd0, ram_we},    32'd0);
            check("rsp_ready", {31'd0, req_ready},  32'd0);
            if (we) model_store(addr, size, wdata);
        end
        @(posedge clk); #1;
        check("idle_valid", {31'd0, resp_valid}, 32'd0);
        check("idle_ready", {31'd0, req_ready},  32'd1);
        check("idle_addr_held", ram_addr, off);
        check("we_cycle_count", we_cycles - we_before, (we && !exp_err) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < RAM_SIZE; i++) ref_mem[i] = 8'($urandom_range(0, 255));
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        check("rst_ready", {31'd0, req_ready},  32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_err",   {31'd0, resp_err},   32'd0);
        check("rst_ram_we", {31'd0, ram_we},    32'd0);
        check("rst_addr",  ram_addr,            32'd0);
        check("rst_mask",  {30'd0, ram_mask},   32'd0);
        check("rst_wdata", ram_wdata,           32'd0);
        check("rst_rdata", resp_rdata,          32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        do_req(1'b1, 2'b10, 1'b0, 32'h1001_0010, 32'h1122_3344, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'd0, 1'b0);
        check("word_roundtrip", model_load(32'h1001_0010, 2'b10, 1'b0), 32'h1122_3344);
        do_req(1'b1, 2'b00, 1'b0, 32'h1001_0003, 32'h5555_55AB, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'h1001_0003, 32'd0, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h1001_0003, 32'd0, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h1001_0001, 32'd0, 1'b0);
        do_req(1'b1, 2'b10, 1'b0, 32'h1001_03FE, 32'hCAFE_F00D, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h1001_03FE, 32'd0, 1'b0);
        do_req(1'b1, 2'b10, 1'b0, 32'h1001_03FC, 32'h8765_4321, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h1001_03FC, 32'd0, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h1000_FFFF, 32'd0, 1'b0);

        // Back-to-back requests with req_valid held high throughout.
        do_req(1'b1, 2'b01, 1'b0, 32'h1001_0040, 32'h0000_9ABC, 1'b1);
        do_req(1'b0, 2'b01, 1'b1, 32'h1001_0040, 32'd0, 1'b1);
        do_req(1'b1, 2'b10, 1'b0, 32'h1001_0044, 32'h0BAD_C0DE, 1'b1);
        do_req(1'b0, 2'b10, 1'b0, 32'h1001_0044, 32'd0, 1'b1);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("hold_no_extra", {31'd0, resp_valid}, 32'd0);

        // Reset in the middle of a store: no write, no response.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h1001_0020; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid_rst_we_pre", {31'd0, ram_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_we_drop", {31'd0, ram_we},    32'd0);
        check("mid_rst_ready",   {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("post_rst_ready", {31'd0, req_ready},  32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h1001_0020, 32'd0, 1'b0);

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = BASE - 32'($urandom_range(1, 16));
            else if (r == 1) a = BASE + 32'd1024 - 32'($urandom_range(0, 5));
            else             a = BASE + 32'($urandom_range(0, 1023));
            sz = 2'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                   $urandom, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the byte-addressed data-memory interface. It takes one load/store request at a time from the multi-cycle core's MEM stage and checks alignment and range.
- It drives the data RAM port (we/addr/mask/signed_ext/wdata), captures rdata, and returns a single-cycle response that reports data or an address error.
- Sits between the core control FSM and the data RAM, and is the only writer of the RAM port.

Parameters:
- BASE_ADDR, 32'h1001_0000, CPU address that maps to RAM byte 0. RAM offset = req_addr - BASE_ADDR (32-bit modular).
- ADDR_BITS, 10, RAM byte-address width. RAM holds 2^ADDR_BITS bytes.
- CHECK_ALIGN, 1, 1 = misaligned half/word accesses raise an error. 0 = no alignment check; misaligned accesses pass through.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 1x word (same encoding as RAM mask)
- req_signed  in  1  sign-extend a byte/half load
- req_addr  in  32  CPU byte address
- req_wdata  in  32  store data, low-justified
- resp_valid  out  1  one-cycle response strobe
- resp_err  out  1  address error; qualified by resp_valid
- resp_rdata  out  32  load data (extended); 0 for stores and errors
- ram_we  out  1  RAM write enable
- ram_addr  out  32  RAM byte offset
- ram_mask  out  2  RAM access size
- ram_signed_ext  out  1  RAM extension control
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM combinational read data

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - All request latches, rdata_q, resp_valid, resp_err, ram_we, ram_addr, ram_mask, ram_signed_ext and ram_wdata go to 0.
  - req_ready = 1 once state is IDLE.
- States: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - req_ready = 1.
  - On req_valid at a rising edge, latch we/size/signed/wdata and offset = req_addr - BASE_ADDR.
  - Compute bytes = 1/2/4 from size.
  - err = (CHECK_ALIGN and ((size==01 and addr[0]) or (size[1] and addr[1:0]!=0))) or (offset + bytes > 2^ADDR_BITS). Evaluate this in 33 bits so there is no wrap.
  - Next state is ERR if err, otherwise ACCESS.
- ACCESS (exactly 1 cycle):
  - ram_addr/mask/signed_ext/wdata come from the latches.
  - ram_we = latched we.
  - Loads: rdata_q <= ram_rdata at the closing edge. Stores: rdata_q <= 0.
  - Next state is RESP.
- RESP: resp_valid = 1, resp_err = 0, resp_rdata = rdata_q. Next state is IDLE.
- ERR:
  - resp_valid = 1, resp_err = 1, resp_rdata = 0.
  - The RAM is never written; ram_we stays 0.
  - Next state is IDLE.
- ram_we is high only in ACCESS for a store; it is 0 in every other state.
- ram_* outputs other than ram_we hold their latched values outside ACCESS. They change only on acceptance or reset.
- Latency:
  - Request accepted at edge N: ACCESS in cycle N+1, resp_valid in cycle N+2.
  - Error path: resp_valid in cycle N+1.
  - Throughput is one request per 3 cycles (2 on the error path).
- req_valid while not in IDLE is ignored and nothing is latched. The requester must hold the request until it sees req_ready.
- resp_valid asserted in RESP/ERR while req_valid is also high: no acceptance that cycle. The request is accepted in the following IDLE cycle.
- Reset during ACCESS:
  - ram_we drops asynchronously, so a store whose edge samples rst = 1 is not written.
  - No response is issued.
- Extension is done by the RAM via ram_signed_ext. The unit passes rdata through unchanged.
- ram_signed_ext = latched signed & ~we.
- Stores send wdata unmodified; the RAM uses only the low bytes selected by mask.
- Offset wrap: req_addr below BASE_ADDR yields a large offset, which raises a range error.

Decomposition:
- Shared package mem_pkg holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state encoding for IDLE/ACCESS/RESP/ERR
  - function size_bytes(size)
- No sub-module is needed. The alignment/range check stays an internal combinational block inside mem_access_unit.

Test Plan:
- Store word 0x11223344 at 0x10010010, then load word at the same address: ram_we high exactly 1 cycle, ram_addr=0x10, resp_valid in cycle N+2, resp_rdata=0x11223344, resp_err=0.
- Store byte 0xAB at 0x10010003, then load byte with signed=1: resp_rdata=0xFFFFFFAB. Same load with signed=0: resp_rdata=0x000000AB.
- Load half at 0x10010001 with CHECK_ALIGN=1: resp_valid=1 and resp_err=1 in cycle N+1, ram_we never high, resp_rdata=0.
- Store word at 0x100103FE (offset 0x3FE, bytes 4 > 1024): error response, RAM contents at 0x3FE and 0x3FF unchanged. Word at 0x100103FC succeeds.
- Hold req_valid high continuously with alternating requests: accepted only in IDLE, one response per request, no duplicate or dropped requests, req_ready=0 during ACCESS/RESP.
- Assert rst mid-ACCESS on a store of 0xDEADBEEF to offset 0x20: ram_we falls immediately, mem[0x20] is unchanged, no resp_valid, req_ready=1 after reset.
